// File: rtl/cpu_fabric_ci_master.sv
// Custom-instruction operand/result master for the east CPU I/O tile column (CI_DONE_FLAG_EN: done-flag capture).
// Capture max(req_lat,1) edges after acceptance, or on done/TIMEOUT; single op in flight, rsp held until rsp_ready.
module cpu_fabric_ci_master #(
  parameter int NUM_TILES = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                     UserCLK,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [4*NUM_TILES-1:0]   req_a,
  input  logic [4*NUM_TILES-1:0]   req_b,
  input  logic [3:0]               req_lat,
  input  logic                     abort,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [4*NUM_TILES-1:0]   rsp_res0,
  output logic [4*NUM_TILES-1:0]   rsp_res1,
  output logic [4*NUM_TILES-1:0]   rsp_res2,
  output logic                     rsp_timeout,
  output logic [4*NUM_TILES-1:0]   opa_o,
  output logic [4*NUM_TILES-1:0]   opb_o,
  input  logic [12*NUM_TILES-1:0]  res_i
);

  localparam int W = 4*NUM_TILES;

`ifdef CI_DONE_FLAG_EN
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
`else
  localparam int CNT_W = 4;
`endif

  // TIMEOUT has to fit the 8-bit wait counter.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_out_of_range
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     res0_d, res1_d, res2_d;
  logic             cap_now;

  for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
    assign res0_d[4*t +: 4] = res_i[12*t     +: 4];
    assign res1_d[4*t +: 4] = res_i[12*t + 4 +: 4];
    assign res2_d[4*t +: 4] = res_i[12*t + 8 +: 4];
  end

  assign req_ready = (state == IDLE) && !reset && !abort;

`ifdef CI_DONE_FLAG_EN
  logic cap_to;
  logic unused_req_lat;
  assign unused_req_lat = ^req_lat;

  // First WAIT cycle (cnt==0) ignores the done flag; done wins over timeout.
  always_comb begin
    cap_now = 1'b0;
    cap_to  = 1'b0;
    if (state == WAIT) begin
      if (cnt != '0 && res_i[8]) begin
        cap_now = 1'b1;
      end else if (cnt == CNT_LAST) begin
        cap_now = 1'b1;
        cap_to  = 1'b1;
      end
    end
  end
`else
  assign cap_now     = (state == WAIT) && (cnt <= 4'd1);
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      opa_o     <= '0;
      opb_o     <= '0;
      rsp_res0  <= '0;
      rsp_res1  <= '0;
      rsp_res2  <= '0;
      rsp_valid <= 1'b0;
`ifdef CI_DONE_FLAG_EN
      rsp_timeout <= 1'b0;
`endif
    end else if (abort && state != IDLE) begin
      // Flush: operands stay on the bus, any pending response is dropped.
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            opa_o <= req_a;
            opb_o <= req_b;
`ifdef CI_DONE_FLAG_EN
            cnt   <= '0;
`else
            cnt   <= (req_lat == 4'd0) ? 4'd1 : req_lat;
`endif
            state <= WAIT;
          end
        end
        WAIT: begin
`ifdef CI_DONE_FLAG_EN
          cnt <= cnt + 1'b1;
`else
          cnt <= cnt - 1'b1;
`endif
          if (cap_now) begin
            rsp_res0  <= res0_d;
            rsp_res1  <= res1_d;
            rsp_res2  <= res2_d;
            rsp_valid <= 1'b1;
`ifdef CI_DONE_FLAG_EN
            rsp_timeout <= cap_to;
`endif
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
